nec_ir_frame_receiver: RTL and testbench

Parametrised NEC infrared frame receiver, the next-generation IR front end of the Christmas tree controller user project. It adds run-time tick period, input polarity, extended-NEC (16-bit address) and repeat-code modes to the fixed-mode receiver. Decoded frames are buffered in an on-block FIFO for the Wishbone/firmware side. `ir_in` comes straight from an `mprj_io` pad.

---
 rtl/nec_ir_pkg.sv | 39 +++
 rtl/nec_ir_fifo.sv | 66 ++++++
 rtl/nec_ir_frame_receiver.sv | 257 +++++++++++++++++++++++++
 tb/tb_nec_ir_frame_receiver.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nec_ir_pkg.sv
// nec_ir_pkg: shared types and timing windows for the NEC IR receiver.
// Window bounds are in half-ticks and inclusive.
package nec_ir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK
    } state_e;

    localparam int LEAD_MARK_MIN = 24;
    localparam int LEAD_MARK_MAX = 40;
    localparam int DATA_SPC_MIN  = 12;
    localparam int DATA_SPC_MAX  = 20;
    localparam int RPT_SPC_MIN   = 6;
    localparam int RPT_SPC_MAX   = 10;
    localparam int MARK_MIN      = 1;
    localparam int MARK_MAX      = 3;
    localparam int SPC0_MIN      = 1;
    localparam int SPC0_MAX      = 3;
    localparam int SPC1_MIN      = 4;
    localparam int SPC1_MAX      = 8;

    localparam int FRAME_W = 25;

    typedef struct packed {
        logic        rpt;
        logic [15:0] addr;
        logic [7:0]  cmd;
    } frame_t;

    function automatic logic in_win(input int d, input int lo, input int hi);
        return (d >= lo) && (d <= hi);
    endfunction

endpackage

// File: rtl/nec_ir_fifo.sv
// nec_ir_fifo: synchronous show-ahead FIFO with fill level.
// A push into a full FIFO is dropped unless a pop happens in the same cycle.
module nec_ir_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      level_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == FULL_LVL);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign rdata   = empty ? '0 : mem_q[rptr_q];
    assign level   = level_q;

    // Storage write; contents are qualified by level so need no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointer and level bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + LW'(1);
            end else if (do_pop && !do_push) begin
                level_q <= level_q - LW'(1);
            end
        end
    end

endmodule

// File: rtl/nec_ir_frame_receiver.sv
// nec_ir_frame_receiver: NEC IR decoder with standard/extended/repeat
// modes; decoded frames are queued in a show-ahead FIFO.
module nec_ir_frame_receiver
    import nec_ir_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [15:0]                 cfg_half_tick,
    input  logic                        cfg_invert,
    input  logic                        cfg_ext_en,
    input  logic                        cfg_repeat_en,
    input  logic                        ir_in,
    output logic [FRAME_W-1:0]          frame_data,
    output logic                        frame_valid,
    input  logic                        frame_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        overflow_clr,
    output logic                        err_pulse,
    output logic                        busy
);

    localparam logic [CNT_W-1:0] DUR_MAX = '1;

    logic             s1_q, s2_q, lvl_q, lvl_d1_q;
    logic             edge_w;
    logic [15:0]      pre_q;
    logic [15:0]      half_m1;
    logic [CNT_W-1:0] dur_q;
    int               dur_i;

    state_e      state_q, state_d;
    logic [31:0] sr_q, sr_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        rpt_q, rpt_d;
    logic [15:0] last_addr_q, last_addr_d;
    logic [7:0]  last_cmd_q, last_cmd_d;
    logic        last_valid_q, last_valid_d;
    logic        err_q, err_d;
    logic        push_q, push_d;
    frame_t      push_frame_q, push_frame_d;
    logic        bad;
    logic        bit_v;
    logic        bit_ok;

    logic [7:0]  b0, b1, b2, b3;
    logic        ovf_q;
    logic        pop_w, drop_w, empty_w;

    assign b0      = sr_q[7:0];
    assign b1      = sr_q[15:8];
    assign b2      = sr_q[23:16];
    assign b3      = sr_q[31:24];
    assign edge_w  = lvl_q ^ lvl_d1_q;
    assign half_m1 = (cfg_half_tick == 16'd0) ? 16'd0
                                              : cfg_half_tick - 16'd1;
    assign dur_i   = int'(dur_q);

    // Pin synchroniser, polarity fix and edge-detect delay stage.
    always_ff @(posedge clk) begin
        s1_q     <= ir_in;
        s2_q     <= s1_q;
        lvl_q    <= s2_q ^ cfg_invert;
        lvl_d1_q <= lvl_q;
    end

    // Half-tick prescaler and saturating duration counter, restarted per edge.
    always_ff @(posedge clk) begin
        if (rst || !en || edge_w) begin
            pre_q <= '0;
            dur_q <= '0;
        end else if (pre_q == half_m1) begin
            pre_q <= '0;
            if (dur_q != DUR_MAX) begin
                dur_q <= dur_q + CNT_W'(1);
            end
        end else begin
            pre_q <= pre_q + 16'd1;
        end
    end

    // Receiver FSM next-state, shift register and frame validation.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        bit_cnt_d    = bit_cnt_q;
        rpt_d        = rpt_q;
        last_addr_d  = last_addr_q;
        last_cmd_d   = last_cmd_q;
        last_valid_d = last_valid_q;
        err_d        = 1'b0;
        push_d       = 1'b0;
        push_frame_d = '0;
        bad          = 1'b0;
        bit_v        = 1'b0;
        bit_ok       = 1'b0;

        if (!en) begin
            state_d   = S_IDLE;
            sr_d      = '0;
            bit_cnt_d = '0;
            rpt_d     = 1'b0;
        end else if (state_q != S_IDLE && dur_q == DUR_MAX) begin
            bad = 1'b1;
        end else if (edge_w) begin
            unique case (state_q)
                S_IDLE: begin
                    if (lvl_q) begin
                        state_d   = S_LEAD_MARK;
                        sr_d      = '0;
                        bit_cnt_d = '0;
                        rpt_d     = 1'b0;
                    end
                end
                S_LEAD_MARK: begin
                    if (in_win(dur_i, LEAD_MARK_MIN, LEAD_MARK_MAX)) begin
                        state_d = S_LEAD_SPACE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_LEAD_SPACE: begin
                    if (in_win(dur_i, DATA_SPC_MIN, DATA_SPC_MAX)) begin
                        state_d   = S_BIT_MARK;
                        bit_cnt_d = '0;
                    end else if (in_win(dur_i, RPT_SPC_MIN, RPT_SPC_MAX)) begin
                        state_d = S_STOP_MARK;
                        rpt_d   = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_BIT_MARK: begin
                    if (in_win(dur_i, MARK_MIN, MARK_MAX)) begin
                        state_d = S_BIT_SPACE;
                    end else begin
                        bad = 1'b1;
                    end
                end
                S_BIT_SPACE: begin
                    if (in_win(dur_i, SPC0_MIN, SPC0_MAX)) begin
                        bit_ok = 1'b1;
                    end else if (in_win(dur_i, SPC1_MIN, SPC1_MAX)) begin
                        bit_ok = 1'b1;
                        bit_v  = 1'b1;
                    end else begin
                        bad = 1'b1;
                    end
                    if (bit_ok) begin
                        sr_d = {bit_v, sr_q[31:1]};
                        if (bit_cnt_q == 5'd31) begin
                            state_d = S_STOP_MARK;
                        end else begin
                            state_d   = S_BIT_MARK;
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                S_STOP_MARK: begin
                    if (!in_win(dur_i, MARK_MIN, MARK_MAX)) begin
                        bad = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        if (rpt_q) begin
                            if (cfg_repeat_en && last_valid_q) begin
                                push_d       = 1'b1;
                                push_frame_d = '{1'b1, last_addr_q, last_cmd_q};
                            end
                        end else if (b3 == ~b2 && (cfg_ext_en || b1 == ~b0)) begin
                            push_d       = 1'b1;
                            push_frame_d.rpt  = 1'b0;
                            push_frame_d.addr = cfg_ext_en ? {b1, b0} : {8'h00, b0};
                            push_frame_d.cmd  = b2;
                            last_addr_d  = push_frame_d.addr;
                            last_cmd_d   = b2;
                            last_valid_d = 1'b1;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (bad) begin
            state_d   = S_IDLE;
            err_d     = 1'b1;
            sr_d      = '0;
            bit_cnt_d = '0;
            rpt_d     = 1'b0;
        end
    end

    // Receiver FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            rpt_q        <= 1'b0;
            last_addr_q  <= '0;
            last_cmd_q   <= '0;
            last_valid_q <= 1'b0;
            err_q        <= 1'b0;
            push_q       <= 1'b0;
            push_frame_q <= '0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            bit_cnt_q    <= bit_cnt_d;
            rpt_q        <= rpt_d;
            last_addr_q  <= last_addr_d;
            last_cmd_q   <= last_cmd_d;
            last_valid_q <= last_valid_d;
            err_q        <= err_d;
            push_q       <= push_d;
            push_frame_q <= push_frame_d;
        end
    end

    // Sticky overflow; a drop in the clearing cycle keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !overflow_clr) || drop_w;
        end
    end

    assign pop_w = frame_ready && !empty_w;

    nec_ir_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (pop_w),
        .wdata (push_frame_q),
        .rdata (frame_data),
        .empty (empty_w),
        .drop  (drop_w),
        .level (fifo_level)
    );

    assign frame_valid = !empty_w;
    assign overflow    = ovf_q;
    assign err_pulse   = err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_nec_ir_frame_receiver.sv
// tb_nec_ir_frame_receiver: directed NEC waveforms with a frame scoreboard.
// Expected frames are queued as waveforms are sent and compared on pop.
module tb_nec_ir_frame_receiver;
    import nec_ir_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] cfg_half_tick = 16'd16;
    logic        cfg_invert = 1'b1;
    logic        cfg_ext_en = 1'b0;
    logic        cfg_repeat_en = 1'b0;
    logic        ir_in = 1'b1;
    logic        frame_ready = 1'b0;
    logic        overflow_clr = 1'b0;
    logic [24:0] frame_data;
    logic        frame_valid;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic        err_pulse;
    logic        busy;

    int     n_chk = 0;
    int     n_fail = 0;
    int     err_cnt = 0;
    frame_t exp_q[$];
    logic [7:0] ta, tc;

    nec_ir_frame_receiver #(
        .FIFO_DEPTH (4),
        .CNT_W      (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .cfg_half_tick (cfg_half_tick),
        .cfg_invert    (cfg_invert),
        .cfg_ext_en    (cfg_ext_en),
        .cfg_repeat_en (cfg_repeat_en),
        .ir_in         (ir_in),
        .frame_data    (frame_data),
        .frame_valid   (frame_valid),
        .frame_ready   (frame_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .overflow_clr  (overflow_clr),
        .err_pulse     (err_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Count cycles with err_pulse high; one per rejected frame expected.
    always @(negedge clk) begin
        if (err_pulse === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t mk(input logic r, input logic [15:0] a,
                                  input logic [7:0] c);
        frame_t f;
        f.rpt  = r;
        f.addr = a;
        f.cmd  = c;
        return f;
    endfunction

    function automatic logic [31:0] wd(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive mark (1) or space (0) for n half-ticks.
    task automatic line(input logic m, input int n);
        ir_in = m ^ cfg_invert;
        cyc(n * int'(cfg_half_tick));
    endtask

    task automatic send_raw(input logic [31:0] w, input int lead, input int lsp,
                            input int nbits, input bit stop);
        line(1'b1, lead);
        line(1'b0, lsp);
        for (int i = 0; i < nbits; i++) begin
            line(1'b1, 2);
            line(1'b0, w[i] ? 6 : 2);
        end
        if (stop) line(1'b1, 2);
        ir_in = cfg_invert;
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_raw(w, 32, 16, 32, 1'b1);
    endtask

    task automatic send_rpt();
        send_raw(32'h0, 32, 8, 0, 1'b1);
    endtask

    task automatic send_std(input logic [7:0] a, input logic [7:0] c,
                            input bit expect_push);
        if (expect_push) exp_q.push_back(mk(1'b0, {8'h00, a}, c));
        send_frame(wd(a, ~a, c, ~c));
    endtask

    task automatic set_inv(input logic v);
        en = 1'b0;
        cfg_invert = v;
        ir_in = v;
        cyc(6);
        en = 1'b1;
    endtask

    task automatic drain();
        frame_t e;
        chk("level_before_drain", 32'(fifo_level), exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("valid", 32'(frame_valid), 1);
            chk("data", 32'(frame_data), 32'(e));
            frame_ready = 1'b1;
            cyc(1);
            frame_ready = 1'b0;
        end
        chk("empty_after_drain", 32'(frame_valid), 0);
    endtask

    initial begin
        cyc(6);
        chk("rst_data", 32'(frame_data), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_err", 32'(err_pulse), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        en = 1'b1;
        cyc(4);

        // repeat code before any data frame is discarded
        cfg_half_tick = 16'd4;
        cfg_repeat_en = 1'b1;
        send_rpt();
        cyc(8);
        chk("rpt_first_level", 32'(fifo_level), 0);
        chk("rpt_first_err", err_cnt, 0);

        // standard frame, with push latency after the stop-mark end
        cfg_half_tick = 16'd16;
        cfg_repeat_en = 1'b0;
        send_std(8'h5A, 8'h3C, 1'b1);
        cyc(4);
        chk("lat_pre", 32'(fifo_level), 0);
        cyc(1);
        chk("lat_push", 32'(fifo_level), 1);
        cyc(8);
        chk("std_err", err_cnt, 0);
        drain();

        // repeat codes after a valid frame
        cfg_half_tick = 16'd4;
        cfg_repeat_en = 1'b1;
        exp_q.push_back(mk(1'b1, 16'h005A, 8'h3C));
        send_rpt();
        cyc(8);
        drain();
        cfg_repeat_en = 1'b0;
        send_rpt();
        cyc(8);
        chk("rpt_off_level", 32'(fifo_level), 0);
        chk("rpt_off_err", err_cnt, 0);

        // extended frame, active-high input
        set_inv(1'b0);
        cfg_ext_en = 1'b1;
        exp_q.push_back(mk(1'b0, 16'h1234, 8'h81));
        send_frame(wd(8'h34, 8'h12, 8'h81, 8'h7E));
        cyc(8);
        chk("ext_err", err_cnt, 0);
        drain();
        cfg_ext_en = 1'b0;
        send_frame(wd(8'h34, 8'h12, 8'h81, 8'h7E));
        cyc(8);
        chk("ext_off_level", 32'(fifo_level), 0);
        chk("ext_off_err", err_cnt, 1);

        // corrupt inverted command byte
        send_frame(wd(8'h5A, 8'hA5, 8'h3C, 8'hC4));
        cyc(8);
        chk("cmdn_level", 32'(fifo_level), 0);
        chk("cmdn_err", err_cnt, 2);

        // short leader rejected, next frame decoded
        send_raw(32'h0, 10, 16, 0, 1'b0);
        cyc(8);
        chk("short_lead_err", err_cnt, 3);
        send_std(8'h10, 8'h22, 1'b1);
        cyc(8);
        chk("after_short_err", err_cnt, 3);
        drain();

        // overflow: six frames into a 4-deep FIFO
        for (int k = 1; k <= 6; k++) begin
            ta = 8'h20 + 8'(k);
            tc = 8'h40 + 8'(k);
            send_std(ta, tc, k <= 4);
            cyc(8);
        end
        chk("ovf_level", 32'(fifo_level), 4);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_head", 32'(frame_data), 32'(exp_q[0]));

        // pop and push in the same cycle while full
        send_std(8'h31, 8'h51, 1'b0);
        cyc(4);
        chk("pp_pop_data", 32'(frame_data), 32'(exp_q[0]));
        frame_ready = 1'b1;
        void'(exp_q.pop_front());
        exp_q.push_back(mk(1'b0, 16'h0031, 8'h51));
        cyc(1);
        frame_ready = 1'b0;
        chk("pp_level", 32'(fifo_level), 4);

        // clear coinciding with a drop keeps overflow set
        send_std(8'h32, 8'h52, 1'b0);
        cyc(4);
        overflow_clr = 1'b1;
        cyc(1);
        overflow_clr = 1'b0;
        chk("clr_vs_drop", 32'(overflow), 1);
        overflow_clr = 1'b1;
        cyc(1);
        overflow_clr = 1'b0;
        chk("clr_plain", 32'(overflow), 0);
        drain();

        // enable dropped mid-frame, then a full frame
        send_raw(wd(8'h66, 8'h99, 8'h77, 8'h88), 32, 16, 12, 1'b0);
        chk("en_busy_mid", 32'(busy), 1);
        en = 1'b0;
        cyc(20);
        chk("en_low_busy", 32'(busy), 0);
        en = 1'b1;
        cyc(4);
        send_std(8'h44, 8'h55, 1'b1);
        cyc(8);
        chk("en_level", 32'(fifo_level), 1);
        chk("en_err", err_cnt, 3);

        // reset mid-frame with a non-empty FIFO
        cfg_repeat_en = 1'b1;
        send_raw(wd(8'h01, 8'hFE, 8'h02, 8'hFD), 32, 16, 5, 1'b0);
        chk("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        cyc(1);
        chk("mr_data", 32'(frame_data), 0);
        chk("mr_valid", 32'(frame_valid), 0);
        chk("mr_level", 32'(fifo_level), 0);
        chk("mr_ovf", 32'(overflow), 0);
        chk("mr_err", 32'(err_pulse), 0);
        chk("mr_busy", 32'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        cyc(4);
        send_rpt();
        cyc(8);
        chk("rpt_after_rst", 32'(fifo_level), 0);
        chk("final_err", err_cnt, 3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
